// File: rtl/if_fetch.sv
// Instruction fetch stage. It issues PC-ordered requests and queues the returned words for IF/ID.
// Ports: clk/rstn, jump redirect, hold stall, mem req/gnt/rvalid bus, inst/addr/valid to decode.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] aq [2];
    logic [31:0] aq_n [2];
    logic [1:0]  qcnt, qcnt_n;
    logic [31:0] baddr [2];
    logic [31:0] baddr_n [2];
    logic [31:0] binst [2];
    logic [31:0] binst_n [2];
    logic [1:0]  bcnt, bcnt_n;
    logic [1:0]  dcnt, dcnt_n;

    logic        pop;
    logic        accept;
    logic        take;
    logic        drop;
    logic [1:0]  load;
    logic [1:0]  pending;

    assign pop     = (bcnt != 2'd0) && !hold_flag_i;
    // A head leaving this cycle frees its slot, which keeps the
    // two-slot loop running at one instruction per cycle.
    assign load    = qcnt + bcnt - {1'b0, pop};
    assign pending = dcnt + qcnt;

    assign mem_req_o  = (state == RUN) && !jump_flag_i
                        && (load < 2'd2);
    assign mem_addr_o = pc;
    assign accept     = mem_req_o && mem_gnt_i;
    assign drop       = mem_rvalid_i && (dcnt != 2'd0);
    assign take       = mem_rvalid_i && (dcnt == 2'd0)
                        && (qcnt != 2'd0);

    assign inst_valid_o = (bcnt != 2'd0);
    assign inst_o       = inst_valid_o ? binst[0] : INST_NOP;
    assign addr_o       = inst_valid_o ? baddr[0] : 32'd0;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        aq_n    = aq;
        qcnt_n  = qcnt;
        baddr_n = baddr;
        binst_n = binst;
        bcnt_n  = bcnt;
        dcnt_n  = dcnt;

        if (jump_flag_i) begin
            pc_n   = jump_addr_i & 32'hFFFF_FFFC;
            qcnt_n = 2'd0;
            bcnt_n = 2'd0;
            // A response landing in the redirect cycle is one of the
            // stale ones, so it is already accounted for here.
            dcnt_n = pending
                     - {1'b0, mem_rvalid_i && (pending != 2'd0)};
        end else begin
            if (accept)
                pc_n = pc + 32'd4;
            if (take) begin
                aq_n[0] = aq[1];
                qcnt_n  = qcnt - 2'd1;
            end
            if (accept) begin
                aq_n[qcnt_n[0]] = pc;
                qcnt_n          = qcnt_n + 2'd1;
            end
            if (pop) begin
                baddr_n[0] = baddr[1];
                binst_n[0] = binst[1];
                bcnt_n     = bcnt - 2'd1;
            end
            if (take) begin
                baddr_n[bcnt_n[0]] = aq[0];
                binst_n[bcnt_n[0]] = mem_rdata_i;
                bcnt_n             = bcnt_n + 2'd1;
            end
            if (drop)
                dcnt_n = dcnt - 2'd1;
        end

        unique case (state)
            BOOT:       state_n = RUN;
            RUN, DRAIN: state_n = (dcnt_n != 2'd0) ? DRAIN : RUN;
            default:    state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            aq[0]    <= 32'd0;
            aq[1]    <= 32'd0;
            qcnt     <= 2'd0;
            baddr[0] <= 32'd0;
            baddr[1] <= 32'd0;
            binst[0] <= 32'd0;
            binst[1] <= 32'd0;
            bcnt     <= 2'd0;
            dcnt     <= 2'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            aq    <= aq_n;
            qcnt  <= qcnt_n;
            baddr <= baddr_n;
            binst <= binst_n;
            bcnt  <= bcnt_n;
            dcnt  <= dcnt_n;
        end
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter INST_NOP, default 32'h0000_0013, instruction value driven when no valid instruction is presented.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port jump_flag_i, input, 1 bit: redirect request from execute.
REQ-006 SHALL have port jump_addr_i, input, 32 bits: redirect target.
REQ-007 SHALL have port hold_flag_i, input, 1 bit: downstream stall; the presented instruction is not consumed.
REQ-008 SHALL have port mem_req_o, output, 1 bit: instruction-memory request valid.
REQ-009 SHALL have port mem_addr_o, output, 32 bits: request address.
REQ-010 SHALL have port mem_gnt_i, input, 1 bit: request accepted when mem_req_o and mem_gnt_i are both 1.
REQ-011 SHALL have port mem_rvalid_i, input, 1 bit: in-order response valid, at least 1 cycle after grant.
REQ-012 SHALL have port mem_rdata_i, input, 32 bits: response instruction word.
REQ-013 SHALL have port inst_o, output, 32 bits: instruction to the IF/ID stage.
REQ-014 SHALL have port addr_o, output, 32 bits: address of inst_o.
REQ-015 SHALL have port inst_valid_o, output, 1 bit: inst_o/addr_o hold a real fetched instruction.

Function
REQ-016 SHALL keep a fetch PC, initialised to RESET_PC; the PC SHALL advance by 4 on each accepted request.
REQ-017 SHALL implement the states BOOT, RUN and DRAIN, with these transitions:
- BOOT -> RUN after 1 cycle.
- RUN -> DRAIN on a jump while responses are outstanding.
- DRAIN -> RUN when the discard count reaches 0.
REQ-018 SHALL limit outstanding requests plus buffer occupancy to at most 2, using a 2-entry in-order buffer of {addr, inst} pairs.
REQ-019 SHALL assert mem_req_o only when all of the following hold:
- the state is RUN;
- jump_flag_i is 0;
- outstanding requests plus occupancy is less than 2.
REQ-020 SHALL drive mem_addr_o from the PC, with mem_addr_o and mem_req_o held stable while mem_req_o is 1 and mem_gnt_i is 0, unless a jump occurs.
REQ-021 SHALL record the address of each granted request in a 2-entry address queue, and pair each mem_rvalid_i with the oldest queued address.
REQ-022 SHALL push {addr, mem_rdata_i} into the buffer on mem_rvalid_i when the discard count is 0.
REQ-023 SHALL drive the outputs as follows:
- inst_valid_o = buffer not empty;
- inst_o/addr_o = buffer head when not empty;
- otherwise inst_o = INST_NOP and addr_o = 0.
REQ-024 SHALL pop the buffer head when inst_valid_o is 1 and hold_flag_i is 0; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-025 SHALL, on jump_flag_i = 1, do all of the following in that cycle:
- clear the buffer;
- set PC to {jump_addr_i[31:2], 2'b00};
- load the discard count with the number of outstanding requests;
- clear the address queue.
REQ-026 SHALL give jump priority over hold; the head SHALL be discarded, not consumed.
REQ-027 SHALL, while the discard count is non-zero, drop each mem_rvalid_i and decrement the count by 1.
REQ-028 SHALL ignore mem_rvalid_i when nothing is outstanding and the discard count is 0.
REQ-029 SHALL let a jump in DRAIN add newly outstanding requests to the discard count; in DRAIN, none are possible, so the count SHALL be retained.
REQ-030 SHALL have a minimum latency, with gnt and rvalid one cycle after grant, of: request in cycle N, rvalid in N+1, inst_valid_o in N+2.
REQ-031 SHALL sustain 1 instruction per cycle with an always-granting memory and hold_flag_i = 0.

Reset
REQ-032 SHALL, on rstn = 0, immediately force all of the following:
- state BOOT;
- PC = RESET_PC;
- buffer, address queue and discard count = 0;
- mem_req_o = 0, inst_valid_o = 0, inst_o = INST_NOP, addr_o = 0.
REQ-033 SHALL abandon any in-flight request on reset mid-operation; responses arriving while rstn = 0 SHALL be ignored.

Verification
REQ-034 SHALL cover reset release with gnt = 1 and rvalid delayed 1 cycle: required result is mem_addr_o = 0, 4, 8 on consecutive cycles; inst_valid_o rises 2 cycles after the first request; addr_o = 0, 4, 8.
REQ-035 SHALL cover hold_flag_i = 1 for 3 cycles with a full buffer: required result is inst_o/addr_o stable, mem_req_o = 0, no instruction lost or duplicated after release.
REQ-036 SHALL cover a jump to 32'h0000_0102 with 2 outstanding requests: required result is that the next 2 rvalids are dropped, the first valid addr_o is 32'h0000_0100, and the state goes DRAIN -> RUN.
REQ-037 SHALL cover jump and hold asserted together with the buffer holding 32'h0000_0010: required result is that the buffer is flushed and inst_valid_o = 0 the next cycle.
REQ-038 SHALL cover mem_gnt_i = 0 for 4 cycles: required result is that mem_req_o and mem_addr_o are held constant and the PC is unchanged.
REQ-039 SHALL cover rstn pulsed low mid-stream with 1 outstanding request: required result is that all outputs are at reset values while rstn = 0, and fetch restarts at RESET_PC.
